testport_write_capture: RTL

//  Sits between the CPU data-memory write bus and the result checker. Detects stores to the test port and

---
 rtl/testport_write_capture_if.sv | 28 ++
 rtl/testport_write_capture.sv | 99 +++++++++
 2 files changed

// File: rtl/testport_write_capture_if.sv
// Bus bundle for the test-port write capture block: the data-memory write bus in, the FIFO and run status out.
// out_stamp exists only when TPCAP_STAMP_EN is defined.
interface testport_write_capture_if;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  run_state;
  logic [15:0] duration;
  logic        overflow;
`ifdef TPCAP_STAMP_EN
  logic [15:0] out_stamp;
`endif

`ifdef TPCAP_STAMP_EN
  modport master (output mem_addr, mem_wdata, mem_wen, out_ready,
                  input  out_valid, out_data, run_state, duration, overflow, out_stamp);
  modport slave  (input  mem_addr, mem_wdata, mem_wen, out_ready,
                  output out_valid, out_data, run_state, duration, overflow, out_stamp);
`else
  modport master (output mem_addr, mem_wdata, mem_wen, out_ready,
                  input  out_valid, out_data, run_state, duration, overflow);
  modport slave  (input  mem_addr, mem_wdata, mem_wen, out_ready,
                  output out_valid, out_data, run_state, duration, overflow);
`endif
endinterface

// File: rtl/testport_write_capture.sv
// Captures test-port stores (one event per wen burst), byte-swaps them, frames runs by BEGIN/END symbols
// and queues words in a FIFO with a registered head. Optional per-word duration stamps: TPCAP_STAMP_EN.
module testport_write_capture #(
  parameter logic [29:0] TEST_ADDR = 30'hFF,
  parameter logic [31:0] BEGIN_SYM = 32'h00000168,
  parameter logic [31:0] END_SYM   = 32'hFFFFFD5D,
  parameter int          DEPTH     = 8
) (
  input logic clk,
  input logic rst,
  testport_write_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        armed, evt, push_req, push, pop, full;
  logic [31:0] sw, head_nxt;
  logic [15:0] duration;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_nxt;
  logic [AW:0]   count, count_nxt;

  assign sw  = {bus.mem_wdata[7:0], bus.mem_wdata[15:8], bus.mem_wdata[23:16], bus.mem_wdata[31:24]};
  assign evt = armed && bus.mem_wen && (bus.mem_addr == TEST_ADDR);

  // A stall-held store keeps wen high; only its first cycle counts.
  always_ff @(posedge clk or negedge rst)
    if (!rst) armed <= 1'b1;
    else      armed <= !bus.mem_wen;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    case (state)
      IDLE:    if (evt && sw == BEGIN_SYM) state_nxt = CAPTURE;
      CAPTURE: if (evt) begin
                 push_req = 1'b1;
                 if (sw == END_SYM) state_nxt = DONE;
               end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst)                                    duration <= '0;
    else if (state == IDLE && state_nxt == CAPTURE) duration <= '0;
    else if (state == CAPTURE && duration != 16'hFFFF) duration <= duration + 16'd1;

  assign full      = (count == FULL_CNT);
  assign pop       = bus.out_valid && bus.out_ready;
  assign push      = push_req && (!full || pop);
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  assign rptr_nxt  = pop ? rptr + AW'(1) : rptr;
  // The new head is the word being written only when it lands in the slot about to be read.
  assign head_nxt  = (push && wptr == rptr_nxt) ? sw : mem[rptr_nxt];

  always_ff @(posedge clk)
    if (push) mem[wptr] <= sw;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      bus.out_data <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      rptr  <= rptr_nxt;
      count <= count_nxt;
      if (count_nxt != '0) bus.out_data <= head_nxt;
      if (push_req && full && !pop) bus.overflow <= 1'b1;
    end

`ifdef TPCAP_STAMP_EN
  logic [15:0] stamp_mem [DEPTH];
  logic [15:0] stamp_nxt;

  assign stamp_nxt = (push && wptr == rptr_nxt) ? duration : stamp_mem[rptr_nxt];

  always_ff @(posedge clk)
    if (push) stamp_mem[wptr] <= duration;

  always_ff @(posedge clk or negedge rst)
    if (!rst)                 bus.out_stamp <= '0;
    else if (count_nxt != '0) bus.out_stamp <= stamp_nxt;
`endif

  assign bus.out_valid = (count != '0);
  assign bus.run_state = state;
  assign bus.duration  = duration;
endmodule
